// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported memory between an instruction-fetch port and a load/store data port.
// Latency: request to x_valid is 2 cycles with a zero-wait memory; the next grant comes one cycle after x_valid.
// Backpressure: a requester is stalled until its x_valid pulse; m_* is held constant until m_ready.
module mem_arbiter #(
    // The starvation counter is two bits wide, so only 0..3 is a meaningful setting.
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        stall_i,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        stall_d,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_size,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);
    localparam logic [2:0] SIZE_BYTE  = 3'b001;
    localparam logic [2:0] SIZE_HALF  = 3'b010;
    localparam logic [2:0] SIZE_WORD  = 3'b100;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_starve_cnt;
    logic [1:0]  w_starve_nxt;

    logic        w_fetch_turn;
    logic        w_grant_i;
    logic        w_grant_d;
    logic [2:0]  w_d_size_fwd;

    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [2:0]  r_m_size;

    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    // Fetch has waited out its budget only if it is still asking.
    assign w_fetch_turn = i_req && (r_starve_cnt == STARVE_LIM);

    // Arbitration happens only in IDLE: data first, unless fetch has been starved.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            if (d_req && !w_fetch_turn) begin
                w_grant_d = 1'b1;
            end else if (i_req) begin
                w_grant_i = 1'b1;
            end
        end
    end

    // Starvation count tracks consecutive data grants that bypassed a waiting fetch.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_i) begin
            w_starve_nxt = 2'd0;
        end else if (w_grant_d) begin
            if (!i_req) begin
                w_starve_nxt = 2'd0;
            end else if (r_starve_cnt < STARVE_LIM) begin
                w_starve_nxt = r_starve_cnt + 2'd1;
            end
        end
    end

    // Unsupported access sizes are widened to a full word.
    always_comb begin
        case (d_size)
            SIZE_BYTE, SIZE_HALF, SIZE_WORD: w_d_size_fwd = d_size;
            default:                         w_d_size_fwd = SIZE_WORD;
        endcase
    end

    // Next-state logic: grant -> busy until m_ready -> one response cycle -> idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = BUSY_I;
                end
            end
            BUSY_I: begin
                if (m_ready) begin
                    w_state_nxt = RESP_I;
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    w_state_nxt = RESP_D;
                end
            end
            RESP_I:  w_state_nxt = IDLE;
            RESP_D:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 2'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Memory request payload is latched at grant and held for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= 32'h0000_0000;
            r_m_wdata <= 32'h0000_0000;
            r_m_size  <= SIZE_WORD;
        end else if (w_grant_d) begin
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_size  <= w_d_size_fwd;
        end else if (w_grant_i) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= i_addr;
            r_m_wdata <= 32'h0000_0000;
            r_m_size  <= SIZE_WORD;
        end
    end

    // Read data capture; stores also capture, and each port holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rdata <= 32'h0000_0000;
            r_d_rdata <= 32'h0000_0000;
        end else if (m_ready) begin
            if (r_state == BUSY_I) begin
                r_i_rdata <= m_rdata;
            end
            if (r_state == BUSY_D) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    // Request and response strobes decode straight from state, so m_ready elsewhere is ignored.
    assign m_req   = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign i_valid = (r_state == RESP_I);
    assign d_valid = (r_state == RESP_D);

    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_size  = r_m_size;

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

    // Stalls are combinational so the pipeline releases in the same cycle as the valid pulse.
    assign stall_i = i_req & ~i_valid;
    assign stall_d = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: exercises mem_arbiter with directed scenarios and random traffic against a transaction-level model.
// Latency: one model step per clock; outputs are sampled on the falling edge, inputs are driven 1 time unit after the rising edge.
// Backpressure: requesters hold req/payload until their valid pulse; the memory answers with random wait states.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        stall_i;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_d;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_size;
    logic        m_ready;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_valid (i_valid),
        .stall_i (stall_i),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_size  (d_size),
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .stall_d (stall_d),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_size  (m_size),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the memory, who gets a response this cycle, starvation count.
    bit          mdl_live = 1'b0;
    bit          mdl_just_rst = 1'b0;
    int          mdl_own = 0;       // 0 none, 1 fetch, 2 data
    int          mdl_resp = 0;      // port whose valid pulses this cycle
    int          mdl_starve = 0;
    int          last_resp = 0;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [2:0]  x_size;
    logic [31:0] x_i_rdata;
    logic [31:0] x_d_rdata;

    // Observations of the DUT, used only to steer directed stimulus and log grants.
    logic        obs_m_req;
    logic [31:0] obs_m_addr;
    logic        obs_i_valid;
    logic        obs_d_valid;
    logic        obs_stall_d;
    logic        prev_m_req;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
    } grant_t;
    grant_t glog[$];

    task automatic step();
        grant_t g;
        @(negedge clk);
        obs_m_req   = m_req;
        obs_m_addr  = m_addr;
        obs_i_valid = i_valid;
        obs_d_valid = d_valid;
        obs_stall_d = stall_d;
        if (m_req === 1'b1 && prev_m_req !== 1'b1) begin
            g.addr = m_addr;
            g.we   = m_we;
            g.size = m_size;
            glog.push_back(g);
        end
        prev_m_req = m_req;
        if (mdl_live) begin
            chk("m_req", 32'(m_req), 32'(mdl_own != 0));
            if (mdl_own != 0 || mdl_just_rst) begin
                chk("m_we",    32'(m_we),   32'(x_we));
                chk("m_addr",  m_addr,      x_addr);
                chk("m_wdata", m_wdata,     x_wdata);
                chk("m_size",  32'(m_size), 32'(x_size));
            end
            chk("i_valid", 32'(i_valid), 32'(mdl_resp == 1));
            chk("d_valid", 32'(d_valid), 32'(mdl_resp == 2));
            chk("i_rdata", i_rdata, x_i_rdata);
            chk("d_rdata", d_rdata, x_d_rdata);
            chk("stall_i", 32'(stall_i), 32'(i_req && mdl_resp != 1));
            chk("stall_d", 32'(stall_d), 32'(d_req && mdl_resp != 2));
        end
        // Advance the model with the inputs applied during this cycle.
        last_resp = mdl_resp;
        if (rst) begin
            mdl_live = 1'b1; mdl_just_rst = 1'b1;
            mdl_own = 0; mdl_resp = 0; mdl_starve = 0;
            x_we = 1'b0; x_addr = 32'h0; x_wdata = 32'h0; x_size = 3'b100;
            x_i_rdata = 32'h0; x_d_rdata = 32'h0;
        end else begin
            mdl_just_rst = 1'b0;
            if (mdl_resp != 0) begin
                mdl_resp = 0;
            end else if (mdl_own != 0) begin
                if (m_ready) begin
                    mdl_resp = mdl_own;
                    if (mdl_own == 1) x_i_rdata = m_rdata;
                    else              x_d_rdata = m_rdata;
                    mdl_own = 0;
                end
            end else if (d_req && !(i_req && mdl_starve >= STARVE_MAX)) begin
                mdl_own = 2;
                x_we = d_we; x_addr = d_addr; x_wdata = d_wdata;
                x_size = (d_size inside {3'b001, 3'b010, 3'b100}) ? d_size : 3'b100;
                if (!i_req)                       mdl_starve = 0;
                else if (mdl_starve < STARVE_MAX) mdl_starve = mdl_starve + 1;
            end else if (i_req) begin
                mdl_own = 1;
                x_we = 1'b0; x_addr = i_addr; x_wdata = 32'h0; x_size = 3'b100;
                mdl_starve = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int port, input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            step();
            seen = (port == 1) ? (obs_i_valid === 1'b1) : (obs_d_valid === 1'b1);
        end
    endtask

    int  lat;
    int  n_iv;
    int  n_busy;
    int  n_stall;
    int  n_dv;
    int  cnt;
    int  d_run[$];
    bit  seen;
    int  pick;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_size = 3'b100;
        m_ready = 1'b0; m_rdata = 32'h0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Fetch alone against a zero-wait memory.
        i_req = 1'b1; i_addr = 32'h100; m_ready = 1'b1; m_rdata = 32'h0050_0093;
        glog.delete();
        lat = -1;
        for (int k = 0; k < 8 && lat < 0; k++) begin
            step();
            if (obs_i_valid === 1'b1) lat = k;
        end
        i_req = 1'b0;
        chk("fetch_latency", 32'(lat), 32'd2);
        chk("fetch_rdata", i_rdata, 32'h0050_0093);
        chk("fetch_grants", 32'(glog.size()), 32'd1);
        if (glog.size() >= 1) begin
            chk("fetch_we",   32'(glog[0].we),   32'd0);
            chk("fetch_size", 32'(glog[0].size), 32'd4);
        end

        // Simultaneous fetch and byte store: data goes first.
        glog.delete();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_size = 3'b001;
        m_rdata = 32'hCAFE_0001;
        run_until(2, 10, seen);
        chk("simul_d_done", 32'(seen), 32'd1);
        d_req = 1'b0;
        run_until(1, 10, seen);
        chk("simul_i_done", 32'(seen), 32'd1);
        i_req = 1'b0;
        chk("simul_grants", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            chk("simul_first_addr", glog[0].addr,       32'h2000);
            chk("simul_first_we",   32'(glog[0].we),    32'd1);
            chk("simul_first_size", 32'(glog[0].size),  32'd1);
            chk("simul_second_addr", glog[1].addr,      32'h200);
        end

        // Starvation: continuous loads with a waiting fetch.
        glog.delete();
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_size = 3'b100; d_wdata = 32'h0;
        n_iv = 0;
        for (int k = 0; k < 60 && n_iv < 2; k++) begin
            step();
            m_rdata = m_rdata + 32'h11;
            if (obs_d_valid === 1'b1) d_addr = d_addr + 32'd4;
            if (obs_i_valid === 1'b1) n_iv++;
        end
        i_req = 1'b0;
        run_until(2, 10, seen);
        d_req = 1'b0;
        d_run.delete();
        cnt = 0;
        foreach (glog[j]) begin
            if (glog[j].addr == 32'h300) begin
                d_run.push_back(cnt);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        chk("starve_fetches", 32'(d_run.size()), 32'd2);
        if (d_run.size() >= 2) begin
            chk("starve_run0", 32'(d_run[0]), 32'd3);
            chk("starve_run1", 32'(d_run[1]), 32'd3);
        end

        // Slow memory on a half-word store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'h1234_5678; d_size = 3'b010;
        m_ready = 1'b0; m_rdata = 32'h0BAD_F00D;
        step();
        n_busy = 0; n_stall = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_m_req === 1'b1)   n_busy++;
            if (obs_stall_d === 1'b1) n_stall++;
        end
        chk("slow_busy",  32'(n_busy),  32'd6);
        chk("slow_stall", 32'(n_stall), 32'd6);
        m_ready = 1'b1;
        run_until(2, 5, seen);
        chk("slow_done", 32'(seen), 32'd1);
        d_req = 1'b0;
        chk("store_rdata", d_rdata, 32'h0BAD_F00D);

        // Reset in the middle of a fetch, with m_ready in the same cycle.
        i_req = 1'b1; i_addr = 32'h600; m_ready = 1'b0;
        step();
        rst = 1'b1; m_ready = 1'b1; m_rdata = 32'h7777_7777;
        step();
        chk("rst_was_busy", 32'(obs_m_req), 32'd1);
        rst = 1'b0; i_addr = 32'h604;
        step();
        chk("rst_mreq",   32'(obs_m_req),   32'd0);
        chk("rst_ivalid", 32'(obs_i_valid), 32'd0);
        step();
        chk("rst_rearb",      32'(obs_m_req), 32'd1);
        chk("rst_rearb_addr", obs_m_addr,     32'h604);
        run_until(1, 5, seen);
        chk("rst_fetch_done", 32'(seen), 32'd1);
        i_req = 1'b0;

        // Stray m_ready in IDLE, then a load with an unsupported size.
        m_ready = 1'b1; m_rdata = 32'h1357_2468;
        step();
        step();
        chk("stray_no_mreq", 32'(obs_m_req), 32'd0);
        glog.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h703; d_size = 3'b011; m_rdata = 32'h2468_ACE0;
        run_until(2, 6, seen);
        d_req = 1'b0;
        n_dv = seen ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (obs_d_valid === 1'b1) n_dv++;
        end
        chk("illegal_dvalid_count", 32'(n_dv), 32'd1);
        chk("illegal_grants", 32'(glog.size()), 32'd1);
        if (glog.size() >= 1) begin
            chk("illegal_size", 32'(glog[0].size), 32'd4);
            chk("illegal_addr", glog[0].addr,      32'h703);
        end

        // Random traffic with wait states and occasional resets.
        for (int k = 0; k < 2000; k++) begin
            if (last_resp == 1 || !i_req) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end
            if (last_resp == 2 || !d_req) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
                pick    = $urandom_range(0, 4);
                case (pick)
                    0:       d_size = 3'b001;
                    1:       d_size = 3'b010;
                    2:       d_size = 3'b100;
                    default: d_size = 3'($urandom);
                endcase
            end
            m_ready = ($urandom_range(0, 2) == 0);
            m_rdata = $urandom;
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end

endmodule
